// File: rtl/mac_request_arbiter.sv
// Round-robin arbiter sharing one MAC request/result port among NUM_REQ engines.
// Optional WAIT watchdog enabled by defining MAC_ARB_TIMEOUT_EN.
module mac_request_arbiter #(
    parameter int WIDTH          = 16,
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_REQ-1:0]                         req_valid,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]                   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]                   req_b,
    input  logic [NUM_REQ*WIDTH-1:0]                   req_c,
    input  logic [NUM_REQ*2-1:0]                       req_mode,
    output logic [NUM_REQ-1:0]                         resp_valid,
    output logic [2*WIDTH-1:0]                         resp_data,
    output logic [WIDTH-1:0]                           mac_a,
    output logic [WIDTH-1:0]                           mac_b,
    output logic [WIDTH-1:0]                           mac_c,
    output logic [1:0]                                 mac_mode,
    output logic [ID_W-1:0]                            mac_id,
    output logic                                       mac_req,
    input  logic                                       mac_ready,
    input  logic [2*WIDTH-1:0]                         mac_result,
    input  logic                                       mac_valid,
    input  logic [ID_W-1:0]                            result_id,
    output logic                                       busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_idx,
    output logic                                       err_id_mismatch,
    output logic                                       err_timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject configurations the id tagging or watchdog cannot represent.
    if (NUM_REQ < 2 || NUM_REQ > 16 || ID_W < PTR_W || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mac_request_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   scan_idx;
    logic               win_found;
    logic               accept;
    logic               issue_done;
    logic               id_match;
    logic               wait_done;
    logic               timeout_fire;
    logic               err_set;

    // Handshake rules: a requester transfer happens on the edge where
    // req_valid[i] && req_ready[i]; the manager transfer on mac_req && mac_ready;
    // a result is consumed on mac_valid && result_id == mac_id while in WAIT.

    // Rotating priority scan starting at rr_ptr.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                winner    = scan_idx;
            end
        end
    end

    assign accept     = (state == ST_IDLE) && win_found;
    assign issue_done = (state == ST_ISSUE) && mac_req && mac_ready;
    assign id_match   = mac_valid && (result_id == mac_id);
    assign wait_done  = (state == ST_WAIT) && id_match;
    // Any result that is not the expected tag in WAIT is a protocol error.
    assign err_set    = mac_valid && !wait_done;
    assign busy       = (state != ST_IDLE);

    // rst_n gating keeps req_ready low while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_done) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_done || timeout_fire) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr          <= '0;
            mac_a           <= '0;
            mac_b           <= '0;
            mac_c           <= '0;
            mac_mode        <= '0;
            mac_id          <= '0;
            mac_req         <= 1'b0;
            grant_idx       <= '0;
            resp_valid      <= '0;
            resp_data       <= '0;
            err_id_mismatch <= 1'b0;
        end else begin
            resp_valid <= '0;
            if (accept) begin
                mac_a     <= req_a[winner*WIDTH +: WIDTH];
                mac_b     <= req_b[winner*WIDTH +: WIDTH];
                mac_c     <= req_c[winner*WIDTH +: WIDTH];
                mac_mode  <= req_mode[winner*2 +: 2];
                mac_id    <= ID_W'(winner);
                grant_idx <= winner;
                rr_ptr    <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
                mac_req   <= 1'b1;
            end
            if (issue_done) begin
                mac_req <= 1'b0;
            end
            if (wait_done) begin
                resp_data             <= mac_result;
                resp_valid[grant_idx] <= 1'b1;
            end else if (timeout_fire) begin
                resp_data             <= '0;
                resp_valid[grant_idx] <= 1'b1;
            end
            if (err_set) begin
                err_id_mismatch <= 1'b1;
            end
        end
    end

`ifdef MAC_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;

    // A matching result on the deadline cycle wins over the timeout.
    assign timeout_fire = (state == ST_WAIT) && !id_match
                          && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (issue_done) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout_fire) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign err_timeout  = 1'b0;
`endif

endmodule
